// File: rtl/sequence_controller.sv
// sequence_controller: eight-phase instruction sequencer for the 8-bit accumulator CPU.
// Ports: clk, rst (sync, active-high); opcode[2:0] from IR[7:5]; zero from ALU;
//        datapath strobes sel/rd/ld_ir/inc_pc/ld_pc/data_e/ld_ac/wr, sticky halt, phase[2:0] for debug.
// All outputs are combinational decodes of the registered phase, opcode and halted flag.
module sequence_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       halt,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   is_hlt, is_skz, is_sto, is_jmp, aluop;

  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    phase_d  = phase_e'(phase_q + 3'd1);   // 3-bit wrap 7 -> 0
    halted_d = halted_q;
    sel      = 1'b0;
    rd       = 1'b0;
    ld_ir    = 1'b0;
    inc_pc   = 1'b0;
    ld_pc    = 1'b0;
    halt     = 1'b0;
    data_e   = 1'b0;
    ld_ac    = 1'b0;
    wr       = 1'b0;

    if (halted_q) begin
      // Frozen in OP_ADDR with every strobe quiet until reset.
      phase_d = phase_q;
      halt    = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          if (is_hlt) begin
            // No PC increment on the HLT cycle so PC stays on the HLT instruction.
            halt     = 1'b1;
            halted_d = 1'b1;
            phase_d  = phase_q;
          end else begin
            inc_pc = 1'b1;
          end
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = is_skz && zero;   // second increment of a taken skip
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: begin
        end
      endcase
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_sequence_controller.sv
// tb_sequence_controller: directed stimulus with hand-computed output words pushed to a scoreboard;
// a negedge monitor pops one expected word per clock and compares it with the DUT outputs.
// Word layout: {phase[2:0], sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}.
module tb_sequence_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;
  logic [2:0] phase;

  sequence_controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .halt   (halt),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] exp;
    string       name;
  } sb_item_t;

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Common instruction-fetch words, phases 0..3.
  localparam logic [11:0] P0 = 12'b000_100000000;
  localparam logic [11:0] P1 = 12'b001_110000000;
  localparam logic [11:0] P2 = 12'b010_111000000;
  localparam logic [11:0] P3 = 12'b011_111000000;
  // Halted (and HLT cycle itself): phase 4, only halt high.
  localparam logic [11:0] PH = 12'b100_000001000;

  // Monitor: one output word per clock, sampled mid-cycle.
  sb_item_t    mon_it;
  logic [11:0] mon_got;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_it  = sb_q.pop_front();
      mon_got = {phase, sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr};
      checks++;
      if (mon_got !== mon_it.exp) begin
        errors++;
        $display("FAIL %s got=%b want=%b (phase sel rd ld_ir inc_pc ld_pc halt data_e ld_ac wr)",
                 mon_it.name, mon_got, mon_it.exp);
      end
    end
  end

  task automatic step(input logic [2:0] op, input logic z, input logic r,
                      input logic [11:0] e, input string nm);
    sb_item_t it;
    opcode = op;
    zero   = z;
    rst    = r;
    it.exp  = e;
    it.name = nm;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // One instruction from phase 0. Opcode is scrambled during phases 0..3 since it must not matter there.
  // abort_ph < 8 asserts rst during that phase and ends the instruction there.
  task automatic run_instr(input string nm, input logic [2:0] op, input logic z,
                           input logic [11:0] e4, input logic [11:0] e5,
                           input logic [11:0] e6, input logic [11:0] e7,
                           input int abort_ph);
    logic [11:0] e [8];
    e[0] = P0; e[1] = P1; e[2] = P2; e[3] = P3;
    e[4] = e4; e[5] = e5; e[6] = e6; e[7] = e7;
    for (int i = 0; i < 8; i++) begin
      step((i < 4) ? (op ^ 3'b101) : op, z, (i == abort_ph),
           e[i], $sformatf("%s_ph%0d", nm, i));
      if (i == abort_ph) return;
    end
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 3'd0;
    zero   = 1'b0;
    @(posedge clk);
    #1;
    // Second reset clock: phase already forced to 0.
    step(3'd3, 1'b1, 1'b1, P0, "reset");

    run_instr("add",  3'd2, 1'b0, 12'b100_000100000, 12'b101_010000000,
              12'b110_010000000, 12'b111_010000010, 8);
    run_instr("and",  3'd3, 1'b1, 12'b100_000100000, 12'b101_010000000,
              12'b110_010000000, 12'b111_010000010, 8);
    run_instr("xor",  3'd4, 1'b0, 12'b100_000100000, 12'b101_010000000,
              12'b110_010000000, 12'b111_010000010, 8);
    run_instr("sto",  3'd6, 1'b1, 12'b100_000100000, 12'b101_000000000,
              12'b110_000000100, 12'b111_000000101, 8);
    run_instr("skz1", 3'd1, 1'b1, 12'b100_000100000, 12'b101_000000000,
              12'b110_000100000, 12'b111_000000000, 8);
    run_instr("skz0", 3'd1, 1'b0, 12'b100_000100000, 12'b101_000000000,
              12'b110_000000000, 12'b111_000000000, 8);
    run_instr("jmp",  3'd7, 1'b0, 12'b100_000100000, 12'b101_000000000,
              12'b110_000010000, 12'b111_000010000, 8);
    // LDA aborted by reset in phase 6: ld_ac must never pulse.
    run_instr("lda_rst", 3'd5, 1'b0, 12'b100_000100000, 12'b101_010000000,
              12'b110_010000000, 12'b111_010000010, 6);
    run_instr("lda",  3'd5, 1'b0, 12'b100_000100000, 12'b101_010000000,
              12'b110_010000000, 12'b111_010000010, 8);

    // HLT: fetch, then halt in phase 4 and stay there regardless of inputs.
    step(3'd5, 1'b0, 1'b0, P0, "hlt_ph0");
    step(3'd5, 1'b0, 1'b0, P1, "hlt_ph1");
    step(3'd5, 1'b0, 1'b0, P2, "hlt_ph2");
    step(3'd5, 1'b0, 1'b0, P3, "hlt_ph3");
    step(3'd0, 1'b0, 1'b0, PH, "hlt_ph4");
    for (int i = 0; i < 22; i++)
      step(3'(i), i[0], 1'b0, PH, $sformatf("hlt_hold%0d", i));
    step(3'd7, 1'b1, 1'b1, PH, "hlt_rst");

    run_instr("add_post_hlt", 3'd2, 1'b0, 12'b100_000100000, 12'b101_010000000,
              12'b110_010000000, 12'b111_010000010, 8);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout pending=%0d", sb_q.size());
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sequence_controller.md
Name: sequence_controller

Overview:
- Eight-phase instruction sequencer for the 8-bit accumulator CPU.
- Drives the accumulator load strobe (ld_ac) and every other datapath control strobe: memory read/write, IR load, PC increment/load, data-bus enable and address-mux select.
- Acts as the initiator for the accumulator, instruction register, program counter and memory.
- Each instruction takes exactly 8 clocks unless halted.

Parameters:
- none (opcode width fixed at 3, phase count fixed at 8)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  3  instruction opcode from IR[7:5]
- zero  in  1  accumulator-is-zero flag from ALU
- sel  out  1  address mux: 1 selects PC, 0 selects IR operand address
- rd  out  1  memory read enable
- ld_ir  out  1  instruction register load
- inc_pc  out  1  program counter increment
- ld_pc  out  1  program counter load (jump)
- halt  out  1  processor halted, sticky until reset
- data_e  out  1  drive accumulator/ALU result onto data bus
- ld_ac  out  1  accumulator load strobe
- wr  out  1  memory write strobe
- phase  out  3  current phase, debug/verification visibility

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset:
  - At a clk edge with rst=1, phase <= 0 (INST_ADDR) and halted flag <= 0.
  - rst overrides all other activity, including a halted state or any mid-instruction phase.
- Output timing: all outputs are combinational decodes of the registered phase, the opcode and the halted flag; there are no output registers.
- Reset output values (phase 0): sel=1; rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr = 0.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP: opcode in {ADD, AND, XOR, LDA}.
- Phase sequencing: phase advances 0→1→…→7→0, one step per clock, with 3-bit wrap from 7 to 0.
- Phase output table (any output not listed is 0):
  - 0 INST_ADDR: sel=1
  - 1 INST_FETCH: sel=1, rd=1
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1
  - 3 IDLE: sel=1, rd=1, ld_ir=1
  - 4 OP_ADDR: inc_pc=1, halt=(opcode==HLT)
  - 5 OP_FETCH: rd=ALUOP
  - 6 ALU_OP: rd=ALUOP, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP), data_e=(opcode==STO)
  - 7 STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=(opcode==JMP), wr=(opcode==STO), data_e=(opcode==STO)
- Halt:
  - If phase==4 and opcode==HLT at a clk edge, the halted flag is set and phase holds at 4.
  - While halted: halt=1, inc_pc=0, and every other output is 0 except sel=0.
  - Only rst clears halt.
  - inc_pc in phase 4 is suppressed on the HLT cycle itself, so the PC is not advanced past the HLT instruction.
- Accumulator load: ld_ac is high for exactly one clock (phase 7) per ALUOP instruction. The accumulator captures the ALU result on the rising edge that ends phase 7.
- SKZ: zero is sampled combinationally during phase 6 only. Together with the phase-4 increment, a taken skip increments the PC twice in one instruction.
- Opcode changes: opcode and zero changes outside the phases listed in the table have no effect.
- Reset mid-instruction: rst asserted in any phase drives phase 0 at the next edge. No wr or ld_ac pulse is produced after that edge.

Test Plan:
- Reset: rst=1 for 2 clocks, then release → phase=0, sel=1, all other outputs 0; phase then counts 1..7,0 on successive edges.
- ADD (opcode=2, zero=0) → ld_ac=1 only in phase 7; rd=1 in phases 1,2,3,5,6,7; wr=0, ld_pc=0 for all 8 cycles; inc_pc=1 only in phase 4.
- STO (opcode=6) → data_e=1 in phases 6 and 7, wr=1 only in phase 7, ld_ac=0 and rd=0 in phases 5–7.
- SKZ: opcode=1 with zero=1 → inc_pc=1 in phases 4 and 6; with zero=0 → inc_pc=1 in phase 4 only. JMP (opcode=7) → ld_pc=1 in phases 6 and 7.
- HLT (opcode=0) → at phase 4, halt=1 and inc_pc=0; phase stays 4 and halt stays 1 for 20+ clocks; then rst=1 for one edge → phase=0, halt=0.
- Reset mid-op: LDA (opcode=5) with rst asserted during phase 6 → next edge phase=0; no ld_ac pulse is observed for that instruction.
